// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
//
// Sequential multi-digit BCD-to-binary converter (reverse double-dabble).
// One word is accepted on the input handshake. Each clock then shifts {B, Y}
// right by one bit and subtracts 3 from every BCD digit of B that is >= 8.
// After N = 4*DIGITS iterations Y holds the binary value. Y is presented on
// the output handshake until the consumer takes it.
//
// Optional feature macro: BCD2BIN_CHECK_EN
//   When this macro is defined, an accepted word that holds any digit > 9
//   goes straight to DONE with bin_out = 0 and err = 1. When it is not
//   defined, err is tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   BCD word present on bcd_in
//   in_ready   out  converter can accept (IDLE only)
//   bcd_in     in   N-bit packed BCD, digit 0 in bits [3:0]
//   out_valid  out  result present on bin_out / err
//   out_ready  in   consumer accepts the result
//   bin_out    out  N-bit unsigned binary result
//   err        out  input contained a digit > 9 (check build only)
// -----------------------------------------------------------------------------
module bcd_to_bin_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bin_out,
  output logic                  err
);

  localparam int N  = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [N-1:0]      b_r, b_s;
  logic [N-1:0]      y_r, y_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [2*N-1:0]    sh_s;

  // Subtract 3 from every digit that is >= 8 (bit 3 set). All digits are
  // corrected in parallel.
  function automatic logic [N-1:0] fix_digits(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i+3]) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef BCD2BIN_CHECK_EN
  logic err_r, err_s;

  // A digit is illegal when it is 1010..1111: bit 3 set together with bit 2 or bit 1.
  function automatic logic has_bad_digit(input logic [N-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i+3] & (v[4*i+2] | v[4*i+1]));
    end
    return bad;
  endfunction
`endif

  // State and working registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      b_r     <= {N{1'b0}};
      y_r     <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
`ifdef BCD2BIN_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      b_r     <= b_s;
      y_r     <= y_s;
      cnt_r   <= cnt_s;
`ifdef BCD2BIN_CHECK_EN
      err_r   <= err_s;
`endif
    end
  end

  // Next-state and datapath update for the three-state sequencer.
  always_comb begin
    state_s = state_r;
    b_s     = b_r;
    y_s     = y_r;
    cnt_s   = cnt_r;
    sh_s    = {b_r, y_r} >> 1;
`ifdef BCD2BIN_CHECK_EN
    err_s   = err_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          b_s   = bcd_in;
          y_s   = {N{1'b0}};
          cnt_s = {CW{1'b0}};
`ifdef BCD2BIN_CHECK_EN
          if (has_bad_digit(bcd_in)) begin
            err_s   = 1'b1;
            state_s = DONE;
          end else begin
            err_s   = 1'b0;
            state_s = SHIFT;
          end
`else
          state_s = SHIFT;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        // B's LSB moves into Y's MSB; only the shifted B gets digit correction.
        b_s   = fix_digits(sh_s[2*N-1:N]);
        y_s   = sh_s[N-1:0];
        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CW'(N - 1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
`ifdef BCD2BIN_CHECK_EN
          err_s   = 1'b0;
`endif
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake flags come from registered state only. The result is gated
  // so that a partial Y is never visible outside DONE.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign bin_out   = (state_r == DONE) ? y_r : {N{1'b0}};
`ifdef BCD2BIN_CHECK_EN
  assign err       = (state_r == DONE) & err_r;
`else
  assign err       = 1'b0;
`endif

endmodule
